// File: rtl/multibyte_add_ctrl.sv
// ----------------------------------------------------------------------------
// multibyte_add_ctrl
//
// Purpose:
//    Computes a W-bit (W = 8*NBYTES) add or subtract by pushing the operands
//    through one 8-bit ripple add slice, one byte per clock, least significant
//    byte first. The carry between bytes is held in a register, so the
//    slice's carry-out of byte i becomes the carry-in of byte i+1.
//    Subtraction is A + ~B + 1. The +1 comes from the carry register being
//    preset to 1 at accept time.
//
// Ports:
//    clk       in   1   rising-edge clock
//    rst_n     in   1   asynchronous active-low reset
//    start     in   1   request, accepted only while busy=0
//    op_sub    in   1   0: a+b, 1: a-b (sampled with start)
//    a         in   W   operand A (sampled with start)
//    b         in   W   operand B (sampled with start)
//    busy      out  1   high while bytes are being processed
//    done      out  1   one-cycle pulse when result/cout/overflow update
//    result    out  W   sum/difference, held until the next done
//    cout      out  1   final carry (subtract: 1 = no borrow)
//    overflow  out  1   signed overflow of the W-bit result
//
// Timing:
//    Accept at edge T. Bytes 0..NBYTES-1 are processed on edges
//    T+1..T+NBYTES. done is high in the cycle after edge T+NBYTES.
//    A start seen while done is high is accepted on that same edge, so
//    back-to-back operations run with no idle bubble.
// ----------------------------------------------------------------------------
module multibyte_add_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  op_sub,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  cout,
   output logic                  overflow
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   logic [IW-1:0]           idx;
   logic                    carry;
   logic [NBYTES-1:0][7:0]  opa;
   logic [NBYTES-1:0][7:0]  opb;
   logic [NBYTES-1:0][7:0]  acc;

   logic [8:0]              slice;
   logic                    msb_cin;

   // The single shared 8-bit add slice. It always works on the byte the
   // index points at. opb already holds ~b for a subtract, so the slice
   // never needs to know which operation is running.
   // The carry into the top bit of the whole word is recovered from the
   // sum bit: s = a ^ b ^ cin, so cin = a ^ b ^ s. This value is only used
   // while the last byte is in the slice.
   always_comb begin
      slice   = {1'b0, opa[idx]} + {1'b0, opb[idx]} + {8'd0, carry};
      msb_cin = opa[NBYTES-1][7] ^ opb[NBYTES-1][7] ^ slice[7];
   end

   // Sequencer, operand and accumulator registers, and the registered
   // outputs, all in one block.
   // - busy and done are flops loaded together with the state, so neither
   //   has a combinational path from start.
   // - The visible result is loaded only on the edge that processes the
   //   last byte. The concatenation takes the fresh top byte straight from
   //   the slice, so partial sums held in acc never reach the output.
   // - The index is cleared when leaving RUN. It therefore never counts
   //   past NBYTES-1, even when NBYTES is not a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         opa      <= '0;
         opb      <= '0;
         acc      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  opa   <= a;
                  opb   <= op_sub ? ~b : b;
                  carry <= op_sub;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            RUN: begin
               acc[idx] <= slice[7:0];
               carry    <= slice[8];
               if (idx == LAST_IDX) begin
                  result   <= {slice[7:0], acc[NBYTES-2:0]};
                  cout     <= slice[8];
                  overflow <= msb_cin ^ slice[8];
                  idx      <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               idx   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multibyte_add_ctrl
//
// Purpose:
//    Self-checking bench for multibyte_add_ctrl with NBYTES=4.
//    It applies three kinds of stimulus:
//    - a table of directed vectors,
//    - hand-written sequences for the multi-cycle corner cases,
//    - a long run of randomized operations.
//    Expected values come from a plain W-bit arithmetic model.
//
// Ports:
//    None. This module is the simulation top.
// ----------------------------------------------------------------------------
module tb_multibyte_add_ctrl;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          op_sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          cout;
   logic          overflow;

   int            check_count = 0;
   int            pass_count  = 0;
   logic [W-1:0]  last_result;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] res;
      logic         c;
      logic         v;
   } vec_t;

   vec_t vecs[10];

   multibyte_add_ctrl #(.NBYTES(NBYTES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model written as whole-word arithmetic.
   // - Add: carry out is bit W of the widened sum. Overflow means both
   //   operands have the same sign and the result sign differs.
   // - Subtract: the carry means no borrow, i.e. x >= y unsigned. Overflow
   //   means the operand signs differ and the result sign differs from x.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, output logic [W-1:0] r,
                                 output logic c, output logic v);
      logic [W:0] full;
      if (!sub) begin
         full = {1'b0, x} + {1'b0, y};
         r    = full[W-1:0];
         c    = full[W];
         v    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end else begin
         full = '0;
         r    = x - y;
         c    = (x >= y);
         v    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
   endfunction

   // One comparison. It counts the check and reports a mismatch on one line.
   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Presents one request for exactly one clock edge. The caller must
   // currently be 1 time unit after a rising edge.
   task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic sub);
      a      = x;
      b      = y;
      op_sub = sub;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Waits, with a cycle bound, for done. While waiting it checks that the
   // previous result stays put on the output.
   task automatic waitDone(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (!done) checkOutput("result held during RUN", result, last_result);
      end while (!done && cyc < 20);
   endtask

   // Runs one full operation and checks latency, the outputs and busy.
   task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sub, input logic [W-1:0] er,
                        input logic ec, input logic ev, input string tag);
      int cyc;
      applyStimulus(x, y, sub);
      checkOutput({tag, " busy after accept"}, W'(busy), W'(1));
      waitDone(cyc);
      checkOutput({tag, " done latency"}, W'(cyc), W'(NBYTES));
      checkOutput({tag, " result"}, result, er);
      checkOutput({tag, " cout"}, W'(cout), W'(ec));
      checkOutput({tag, " overflow"}, W'(overflow), W'(ev));
      checkOutput({tag, " busy in DONE"}, W'(busy), W'(0));
      last_result = er;
   endtask

   // Draws an operand, biased toward the sign and carry boundaries.
   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return $urandom;
      endcase
   endfunction

   // Main test sequence.
   initial begin
      logic [W-1:0] er, r1, r2, cap;
      logic         ec, ev, c1, v1, c2, v2;
      int           cyc, done_count, done_at;

      rst_n       = 1'b1;
      start       = 1'b0;
      op_sub      = 1'b0;
      a           = '0;
      b           = '0;
      last_result = '0;

      // Reset state.
      #3 rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset busy", W'(busy), W'(0));
      checkOutput("reset done", W'(done), W'(0));
      checkOutput("reset result", result, '0);
      checkOutput("reset cout", W'(cout), W'(0));
      checkOutput("reset overflow", W'(overflow), W'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors with hand-derived expectations.
      vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[4] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
      vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
      vecs[8] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
      vecs[9] = '{32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         runOp(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].c,
               vecs[i].v, $sformatf("vec%0d", i));
      end

      // Start pulsed with new operands during RUN must be ignored.
      model(32'h11111111, 32'h22222222, 1'b0, er, ec, ev);
      applyStimulus(32'h11111111, 32'h22222222, 1'b0);
      a      = 32'hFFFFFFFF;
      b      = 32'h00000001;
      op_sub = 1'b1;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      done_count = 0;
      done_at    = 0;
      cap        = '0;
      for (int k = 2; k <= 13; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_count++;
            done_at = k;
            cap     = result;
         end
      end
      checkOutput("ignored start done count", W'(done_count), W'(1));
      checkOutput("ignored start done cycle", W'(done_at), W'(NBYTES));
      checkOutput("ignored start result", cap, er);
      checkOutput("ignored start busy", W'(busy), W'(0));
      last_result = er;

      // Reset pulse mid-RUN aborts the operation with no done.
      applyStimulus(32'h01020304, 32'h0A0B0C0D, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", W'(busy), W'(0));
      checkOutput("abort done", W'(done), W'(0));
      checkOutput("abort result", result, '0);
      checkOutput("abort cout", W'(cout), W'(0));
      checkOutput("abort overflow", W'(overflow), W'(0));
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      last_result = '0;
      done_count  = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (done) done_count++;
      end
      checkOutput("abort no done", W'(done_count), W'(0));
      model(32'h10000000, 32'h00000001, 1'b1, er, ec, ev);
      runOp(32'h10000000, 32'h00000001, 1'b1, er, ec, ev, "after abort");

      // Start held high across DONE gives a back-to-back accept, so the two
      // done pulses are NBYTES+1 cycles apart.
      model(32'h12345678, 32'h0FEDCBA9, 1'b0, r1, c1, v1);
      model(32'h00000003, 32'h80000000, 1'b1, r2, c2, v2);
      a      = 32'h12345678;
      b      = 32'h0FEDCBA9;
      op_sub = 1'b0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      waitDone(cyc);
      checkOutput("b2b first latency", W'(cyc), W'(NBYTES));
      checkOutput("b2b first result", result, r1);
      checkOutput("b2b first cout", W'(cout), W'(c1));
      checkOutput("b2b first overflow", W'(overflow), W'(v1));
      last_result = r1;
      a      = 32'h00000003;
      b      = 32'h80000000;
      op_sub = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b accept busy", W'(busy), W'(1));
      checkOutput("b2b accept done", W'(done), W'(0));
      waitDone(cyc);
      checkOutput("b2b done spacing", W'(cyc + 1), W'(NBYTES + 1));
      checkOutput("b2b second result", result, r2);
      checkOutput("b2b second cout", W'(cout), W'(c2));
      checkOutput("b2b second overflow", W'(overflow), W'(v2));
      last_result = r2;

      // Randomized operations against the arithmetic model.
      for (int n = 0; n < 1000; n++) begin
         logic [W-1:0] x, y;
         logic         s;
         x = pick();
         y = pick();
         s = 1'($urandom_range(0, 1));
         model(x, y, s, er, ec, ev);
         runOp(x, y, s, er, ec, ev, $sformatf("rand%0d", n));
      end

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
